ex_mem_skid_reg: RTL and testbench
==================================

// Module: ex_mem_skid_reg
// PURPOSE
//   Parametrised EX->MEM pipeline register with valid/ready handshake and a 2-entry skid buffer.
//   Carries ALU result, store data, destination register, PC+4 and a control sideband.
//   Sits between the execute datapath and data-memory access. Supports back-pressure from
//   a multi-cycle memory and a synchronous flush from the hazard unit.
// PARAMETERS
//   XLEN    32  width of ALU result, store data and PC+4 fields
//   REG_AW  5   width of destination register index
//   CTRL_W  4   width of control sideband (e.g. RegWrite, MemWrite, ResultSrc[1:0])
//   CNT_W   16  width of stall counter (used only with EX_MEM_STALL_CNT_EN)
// PORTS
//   clk         in   1       clock, rising edge
//   reset_n     in   1       asynchronous active-low reset
//   flush       in   1       synchronous flush; drops all held entries
//   in_valid    in   1       EX beat valid
//   in_ready    out  1       register can accept a beat
//   ALUResultE  in   XLEN    ALU result
//   WriteDataE  in   XLEN    store data
//   RdE         in   REG_AW  destination register
//   PCPlus4E    in   XLEN    PC+4
//   CtrlE       in   CTRL_W  control sideband
//   out_valid   out  1       MEM beat valid
//   out_ready   in   1       MEM stage consumes beat
//   ALUResultM  out  XLEN    held ALU result
//   WriteDataM  out  XLEN    held store data
//   RdM         out  REG_AW  held dest reg; reads 0 whenever out_valid=0
//   PCPlus4M    out  XLEN    held PC+4
//   CtrlM       out  CTRL_W  held control; reads 0 whenever out_valid=0
//   stall_cnt   out  CNT_W   back-pressure cycle count (only with EX_MEM_STALL_CNT_EN)
// BEHAVIOUR
//   - One clock (clk); reset is asynchronous, active-low (reset_n). On reset assertion: main and
//     skid data regs all 0, both valids 0, state EMPTY; in_ready=1, out_valid=0, all M outputs 0.
//   - accept = in_valid & in_ready; drain = out_valid & out_ready.
//   - Storage: main entry (drives M outputs) + skid entry. in_ready = !skid_valid (pure register
//     output, no combinational path from out_ready). out_valid = main_valid.
//   - States: EMPTY (0 held), ONE (main only), FULL (main+skid).
//     EMPTY: accept -> ONE, main <= E fields.
//     ONE:   accept&drain -> ONE, main <= E; accept&!drain -> FULL, skid <= E;
//            !accept&drain -> EMPTY; else hold.
//     FULL:  in_ready=0; drain -> ONE, main <= skid; else hold.
//   - Latency: 1 cycle accept-to-out_valid when not back-pressured; full throughput 1 beat/cycle.
//   - Ordering strictly FIFO; no beat duplicated or lost except by flush.
//   - flush highest priority: next state EMPTY, both valids 0; a beat presented with in_valid&in_ready
//     in the flush cycle counts as accepted and discarded. Data regs need not clear, but RdM/CtrlM
//     gated to 0 by out_valid=0.
//   - Holding: M outputs stable while out_valid&!out_ready.
//   - RdE=0 passed unchanged (writeback ignores x0).
//   - reset_n assertion mid-transfer: entries discarded immediately, no partial beat emitted.
// CONFIGURATION
//   EX_MEM_STALL_CNT_EN defined: stall_cnt port present; increments each cycle with
//     out_valid&!out_ready, saturates at all-ones, cleared only by reset_n (not by flush).
//   Not defined: stall_cnt port and counter logic absent; all other behaviour identical.
// TESTING
//   - Reset: hold reset_n=0 with in_valid=1 -> in_ready=1, out_valid=0, RdM=0, CtrlM=0, ALUResultM=0.
//   - Streaming: out_ready=1, beats ALU=0x10,0x20,0x30 on consecutive cycles -> same values on
//     ALUResultM 1 cycle later each, out_valid continuous, in_ready stays 1.
//   - Back-pressure: out_ready=0, send 0xA,0xB,0xC -> 0xA held, 0xB in skid, in_ready=0 after 2nd,
//     0xC held upstream; release out_ready -> 0xA,0xB,0xC drained in order, no gaps.
//   - Flush in FULL: flush=1 with 2 held + in_valid=1 (Rd=5) -> next cycle out_valid=0, RdM=0,
//     in_ready=1; next beat Rd=7 appears alone.
//   - Stall counter (macro on, CNT_W=4): out_valid held with out_ready=0 for 20 cycles -> stall_cnt=15.

Source files
------------

// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg: EX->MEM pipeline register, valid/ready handshake, 2-entry skid buffer.
// Optional back-pressure counter enabled by defining EX_MEM_STALL_CNT_EN.
module ex_mem_skid_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 4
`ifdef EX_MEM_STALL_CNT_EN
    ,parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   ALUResultE,
    input  logic [XLEN-1:0]   WriteDataE,
    input  logic [REG_AW-1:0] RdE,
    input  logic [XLEN-1:0]   PCPlus4E,
    input  logic [CTRL_W-1:0] CtrlE,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   ALUResultM,
    output logic [XLEN-1:0]   WriteDataM,
    output logic [REG_AW-1:0] RdM,
    output logic [XLEN-1:0]   PCPlus4M,
    output logic [CTRL_W-1:0] CtrlM
`ifdef EX_MEM_STALL_CNT_EN
    ,output logic [CNT_W-1:0] stall_cnt
`endif
);
    localparam int BW = 3*XLEN + REG_AW + CTRL_W;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state, state_nxt;
    logic [BW-1:0] main_q, skid_q, in_bus;
    logic [REG_AW-1:0] rd_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic accept, drain, load_main, load_skid, main_from_skid;
    assign in_bus = {ALUResultE, WriteDataE, RdE, PCPlus4E, CtrlE};
    assign in_ready = state != FULL;
    assign out_valid = state != EMPTY;
    assign accept = in_valid & in_ready;
    assign drain = out_valid & out_ready;
    assign {ALUResultM, WriteDataM, rd_q, PCPlus4M, ctrl_q} = main_q;
    assign RdM = out_valid ? rd_q : '0;
    assign CtrlM = out_valid ? ctrl_q : '0;
    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                load_main = accept;
                state_nxt = accept ? ONE : EMPTY;
            end
            ONE: begin
                load_main = accept & drain;
                load_skid = accept & !drain;
                state_nxt = load_skid ? FULL : (!accept & drain) ? EMPTY : ONE;
            end
            FULL: begin
                main_from_skid = drain;
                state_nxt = drain ? ONE : FULL;
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) state_nxt = EMPTY;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nxt;
            if (load_main) main_q <= in_bus;
            else if (main_from_skid) main_q <= skid_q;
            if (load_skid) skid_q <= in_bus;
        end
    end
`ifdef EX_MEM_STALL_CNT_EN
    // saturating; flush deliberately leaves it untouched
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_cnt <= '0;
        else if (out_valid & !out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// tb_ex_mem_skid_reg: queue-model checker plus directed vectors for ex_mem_skid_reg.
module tb_ex_mem_skid_reg;
    localparam int CNT_W = 4;
    typedef struct {
        logic [31:0] alu, wd, pc;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
    } beat_t;
    logic clk = 1'b0, reset_n = 1'b0, flush = 1'b0, in_valid = 1'b1, out_ready = 1'b0;
    logic in_ready, out_valid;
    logic [31:0] ALUResultE = '0, WriteDataE = '0, PCPlus4E = '0;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0] RdE = '0, RdM;
    logic [3:0] CtrlE = '0, CtrlM;
`ifdef EX_MEM_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif
    int n_cmp = 0, n_bad = 0, sc = 0;
    beat_t q[$];
    always #5 clk = ~clk;
    ex_mem_skid_reg #(
        .XLEN(32), .REG_AW(5), .CTRL_W(4)
`ifdef EX_MEM_STALL_CNT_EN
        ,.CNT_W(CNT_W)
`endif
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .RdE(RdE), .PCPlus4E(PCPlus4E),
        .CtrlE(CtrlE), .out_valid(out_valid), .out_ready(out_ready), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M), .CtrlM(CtrlM)
`ifdef EX_MEM_STALL_CNT_EN
        ,.stall_cnt(stall_cnt)
`endif
    );
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask
    // Model: up to two accepted beats in order; head is what MEM sees.
    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            q.delete();
            sc = 0;
        end else begin
            bit acc, drn;
            beat_t b;
            acc = in_valid && q.size() < 2;
            drn = q.size() > 0 && out_ready;
            if (q.size() > 0 && !out_ready && sc < (1 << CNT_W) - 1) sc++;
            b.alu = ALUResultE; b.wd = WriteDataE; b.pc = PCPlus4E; b.rd = RdE; b.ctrl = CtrlE;
            if (flush) q.delete();
            else begin
                if (drn) void'(q.pop_front());
                if (acc) q.push_back(b);
            end
        end
    end
    initial forever begin
        @(negedge clk);
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_valid", out_valid, q.size() > 0);
        chk("RdM", RdM, q.size() > 0 ? q[0].rd : 5'd0);
        chk("CtrlM", CtrlM, q.size() > 0 ? q[0].ctrl : 4'd0);
        if (q.size() > 0) begin
            chk("ALUResultM", ALUResultM, q[0].alu);
            chk("WriteDataM", WriteDataM, q[0].wd);
            chk("PCPlus4M", PCPlus4M, q[0].pc);
        end
`ifdef EX_MEM_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, sc);
`endif
    end
    task automatic step(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                        input logic ordy, input logic fl);
        in_valid = v; ALUResultE = alu; WriteDataE = alu ^ 32'h5555_0000;
        PCPlus4E = alu + 32'd4; RdE = rd; CtrlE = alu[3:0] ^ rd[3:0];
        out_ready = ordy; flush = fl;
        @(posedge clk);
        #2;
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_RdM", RdM, 0);
        chk("rst_CtrlM", CtrlM, 0);
        chk("rst_ALUResultM", ALUResultM, 0);
        reset_n = 1'b1;
        step(1, 32'h10, 5'd1, 1, 0); chk("str_a", ALUResultM, 32'h10); chk("str_v", out_valid, 1);
        step(1, 32'h20, 5'd2, 1, 0); chk("str_b", ALUResultM, 32'h20); chk("str_rdy", in_ready, 1);
        step(1, 32'h30, 5'd3, 1, 0); chk("str_c", ALUResultM, 32'h30); chk("str_v2", out_valid, 1);
        step(0, 32'h0, 5'd0, 1, 0); chk("str_end", out_valid, 0);
        step(1, 32'hA, 5'd4, 0, 0); chk("bp_a", ALUResultM, 32'hA); chk("bp_rdy1", in_ready, 1);
        step(1, 32'hB, 5'd5, 0, 0); chk("bp_hold", ALUResultM, 32'hA); chk("bp_rdy0", in_ready, 0);
        step(1, 32'hC, 5'd6, 0, 0); chk("bp_hold2", ALUResultM, 32'hA); chk("bp_rd", RdM, 4);
        step(1, 32'hC, 5'd6, 1, 0); chk("bp_b", ALUResultM, 32'hB); chk("bp_rdy1b", in_ready, 1);
        step(1, 32'hC, 5'd6, 1, 0); chk("bp_c", ALUResultM, 32'hC); chk("bp_v", out_valid, 1);
        step(0, 32'h0, 5'd0, 1, 0); chk("bp_end", out_valid, 0);
        step(1, 32'h1, 5'd1, 0, 0);
        step(1, 32'h2, 5'd2, 0, 0);
        step(1, 32'h3, 5'd5, 0, 1);
        chk("fl_v", out_valid, 0); chk("fl_rd", RdM, 0); chk("fl_rdy", in_ready, 1);
        step(1, 32'h7, 5'd7, 1, 0); chk("fl_next_rd", RdM, 7); chk("fl_next_alu", ALUResultM, 32'h7);
        step(0, 32'h0, 5'd0, 1, 0); chk("fl_alone", out_valid, 0);
        step(1, 32'h8, 5'd8, 0, 0);
        step(1, 32'h9, 5'd9, 0, 1); chk("fl_acc_drop", out_valid, 0);
        step(1, 32'h44, 5'd0, 1, 0); chk("x0_v", out_valid, 1); chk("x0_rd", RdM, 0);
        chk("x0_ctrl", CtrlM, 4'h4);
        step(1, 32'h55, 5'd3, 0, 0);
        #1 reset_n = 1'b0;
        #1 chk("async_v", out_valid, 0); chk("async_rd", RdM, 0); chk("async_rdy", in_ready, 1);
        @(posedge clk);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 40; i++)
            step(i % 3 != 0, 32'h111 * i, 5'(i), i % 4 != 1, i == 25);
        step(0, 32'h0, 5'd0, 1, 0);
`ifdef EX_MEM_STALL_CNT_EN
        reset_n = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        step(1, 32'h66, 5'd6, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 32'h0, 5'd0, 0, 0);
        chk("stall_sat", stall_cnt, 15);
        step(0, 32'h0, 5'd0, 0, 1);
        chk("stall_flush_keep", stall_cnt, 15);
`endif
        @(negedge clk);
        #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
